// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: load/store op codes, FSM states and
// a decoder that maps an op code to its access width and signedness.
package mem_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic {IDLE, WAIT} state_t;

  typedef enum logic [1:0] {BYTE, HALF, WORD} width_t;

  typedef struct packed {
    logic   valid;
    width_t width;
    logic   is_signed;
  } op_info_t;

  function automatic op_info_t decode_op(input logic [5:0] op);
    op_info_t info;
    info.valid     = 1'b1;
    info.width     = WORD;
    info.is_signed = 1'b0;
    case (op)
      OP_LB:  begin info.width = BYTE; info.is_signed = 1'b1; end
      OP_LH:  begin info.width = HALF; info.is_signed = 1'b1; end
      OP_LW:  info.width = WORD;
      OP_LBU: info.width = BYTE;
      OP_LHU: info.width = HALF;
      OP_SB:  info.width = BYTE;
      OP_SH:  info.width = HALF;
      OP_SW:  info.width = WORD;
      default: info.valid = 1'b0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Big-endian lane steering: byte enables and replicated store data on the way
// out, lane selection and sign/zero extension of load data on the way back.
module mem_align
  import mem_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal
);

  op_info_t    info;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign info = decode_op(op);

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[31:24];
      2'd1:    byte_sel = rdata[23:16];
      2'd2:    byte_sel = rdata[15:8];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[15:0] : rdata[31:16];

    case (info.width)
      BYTE: begin
        be        = 4'b1000 >> addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{info.is_signed & byte_sel[7]}}, byte_sel};
      end
      HALF: begin
        be        = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{info.is_signed & half_sel[15]}}, half_sel};
      end
      default: begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
      end
    endcase

    // An undecodable op has no meaningful width, so only illegal is reported.
    misaligned = info.valid &&
                 (((info.width == HALF) && addr_lo[0]) ||
                  ((info.width == WORD) && (addr_lo != 2'b00)));
    illegal    = !info.valid;
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: runs loads/stores over a req/ack port, stalls upstream while
// an access is outstanding, and registers the MEM/WB pipeline fields.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr1_IN,
  input  logic [31:0] Instr1_PC_IN,
  input  logic [31:0] ALU_result1_IN,
  input  logic [4:0]  WriteRegister1_IN,
  input  logic [31:0] MemWriteData1_IN,
  input  logic        RegWrite1_IN,
  input  logic [5:0]  ALU_Control1_IN,
  input  logic        MemRead1_IN,
  input  logic        MemWrite1_IN,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        Stall_OUT,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr1_PC_OUT,
  output logic [31:0] WriteData1_OUT,
  output logic [4:0]  WriteRegister1_OUT,
  output logic        RegWrite1_OUT,
  output logic        MemErr1_OUT
);

  localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]     lat_addr, lat_sdata, lat_instr, lat_pc;
  logic [5:0]      lat_op;
  logic [4:0]      lat_wreg;
  logic            lat_we, lat_regwrite;

  logic        in_wait, mem_op, access_err, legal_req, timeout, retire_err;
  logic        is_mem, complete, misaligned, illegal;
  logic [3:0]  be;
  logic [31:0] wdata, load_data;
  logic [5:0]  cur_op;
  logic [31:0] cur_addr, cur_sdata, src_instr, src_pc;
  logic [4:0]  src_wreg;
  logic        src_regwrite;

  // While waiting, the bus and the retiring instruction come from the latched copy.
  assign in_wait      = (state == WAIT);
  assign cur_op       = in_wait ? lat_op       : ALU_Control1_IN;
  assign cur_addr     = in_wait ? lat_addr     : ALU_result1_IN;
  assign cur_sdata    = in_wait ? lat_sdata    : MemWriteData1_IN;
  assign src_instr    = in_wait ? lat_instr    : Instr1_IN;
  assign src_pc       = in_wait ? lat_pc       : Instr1_PC_IN;
  assign src_wreg     = in_wait ? lat_wreg     : WriteRegister1_IN;
  assign src_regwrite = in_wait ? lat_regwrite : RegWrite1_IN;

  mem_align u_align (
    .op         (cur_op),
    .addr_lo    (cur_addr[1:0]),
    .store_data (cur_sdata),
    .rdata      (dmem_rdata),
    .be         (be),
    .wdata      (wdata),
    .load_data  (load_data),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

  assign mem_op     = MemRead1_IN | MemWrite1_IN;
  assign access_err = mem_op & (illegal | misaligned | (MemRead1_IN & MemWrite1_IN));
  assign legal_req  = !in_wait & mem_op & !access_err;
  assign timeout    = in_wait & (cnt == CNT_MAX);
  assign retire_err = (!in_wait & access_err) | timeout;
  assign is_mem     = in_wait | mem_op;

  assign dmem_req   = legal_req | (in_wait & !timeout);
  assign dmem_we    = in_wait ? lat_we : MemWrite1_IN;
  assign dmem_addr  = {cur_addr[31:2], 2'b00};
  assign dmem_be    = be;
  assign dmem_wdata = wdata;
  assign complete   = dmem_req & dmem_ack;
  assign Stall_OUT  = dmem_req & !dmem_ack;

  // A stalled edge writes a bubble so WB never sees the same instruction twice.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state              <= IDLE;
      cnt                <= '0;
      Instr1_OUT         <= '0;
      Instr1_PC_OUT      <= '0;
      WriteData1_OUT     <= '0;
      WriteRegister1_OUT <= '0;
      RegWrite1_OUT      <= 1'b0;
      MemErr1_OUT        <= 1'b0;
    end else begin
      if (Stall_OUT) begin
        RegWrite1_OUT <= 1'b0;
        Instr1_OUT    <= '0;
        MemErr1_OUT   <= 1'b0;
      end else begin
        Instr1_OUT         <= src_instr;
        Instr1_PC_OUT      <= src_pc;
        WriteRegister1_OUT <= src_wreg;
        MemErr1_OUT        <= retire_err;
        RegWrite1_OUT      <= src_regwrite & !retire_err & !(is_mem & dmem_we);
        WriteData1_OUT     <= (complete & !dmem_we) ? load_data : cur_addr;
      end

      case (state)
        IDLE: begin
          if (legal_req && !dmem_ack) begin
            state        <= WAIT;
            cnt          <= CNT_W'(1);
            lat_addr     <= ALU_result1_IN;
            lat_sdata    <= MemWriteData1_IN;
            lat_op       <= ALU_Control1_IN;
            lat_we       <= MemWrite1_IN;
            lat_regwrite <= RegWrite1_IN;
            lat_wreg     <= WriteRegister1_IN;
            lat_instr    <= Instr1_IN;
            lat_pc       <= Instr1_PC_IN;
          end
        end
        WAIT: begin
          if (dmem_ack || timeout) state <= IDLE;
          else cnt <= cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomised bench for mem_stage: a per-instruction reference model predicts
// bus signals, stall length and the retired MEM/WB fields.
module tb_mem_stage;

  localparam int TIMEOUT = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Instr1_IN, Instr1_PC_IN, ALU_result1_IN, MemWriteData1_IN;
  logic [4:0]  WriteRegister1_IN;
  logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN;
  logic [5:0]  ALU_Control1_IN;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        Stall_OUT, RegWrite1_OUT, MemErr1_OUT;
  logic [31:0] Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT;
  logic [4:0]  WriteRegister1_OUT;

  int compare_count = 0;
  int mismatch_count = 0;

  mem_stage #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET),
    .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN),
    .ALU_result1_IN(ALU_result1_IN), .WriteRegister1_IN(WriteRegister1_IN),
    .MemWriteData1_IN(MemWriteData1_IN), .RegWrite1_IN(RegWrite1_IN),
    .ALU_Control1_IN(ALU_Control1_IN), .MemRead1_IN(MemRead1_IN),
    .MemWrite1_IN(MemWrite1_IN),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .Stall_OUT(Stall_OUT),
    .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT),
    .WriteData1_OUT(WriteData1_OUT), .WriteRegister1_OUT(WriteRegister1_OUT),
    .RegWrite1_OUT(RegWrite1_OUT), .MemErr1_OUT(MemErr1_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compare_count++;
    if (actual !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the retiring rising edge.
  // latency: 0 = ack with the request, n = ack in the n-th wait cycle, -1 = never.
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] addr,
                               input logic [31:0] sdata, input logic [31:0] rdata,
                               input logic rd, input logic wr, input logic rw,
                               input logic [4:0] wreg, input int latency);
    logic [31:0] instr, pc, exp_wdata, exp_load, v;
    logic [3:0]  exp_be;
    int          width, idx, stall_cycles;
    bit          sgn, valid, err, legal, timed_out, exp_rw;

    instr = $urandom;
    pc    = $urandom;
    valid = 1; sgn = 0; width = 4;
    case (op)
      6'h20: begin width = 1; sgn = 1; end
      6'h21: begin width = 2; sgn = 1; end
      6'h23: width = 4;
      6'h24: width = 1;
      6'h25: width = 2;
      6'h28: width = 1;
      6'h29: width = 2;
      6'h2B: width = 4;
      default: valid = 0;
    endcase
    idx       = int'(addr % 4);
    err       = (rd || wr) && ((rd && wr) || !valid || (idx % width != 0));
    legal     = (rd || wr) && !err;
    timed_out = legal && (latency < 0);

    if (width == 1) begin
      exp_be    = 4'b0001 << (3 - idx);
      exp_wdata = (sdata & 32'hFF) * 32'h01010101;
      v         = (rdata >> (8 * (3 - idx))) & 32'hFF;
      exp_load  = (sgn && v >= 32'h80) ? v + 32'hFFFFFF00 : v;
    end else if (width == 2) begin
      exp_be    = 4'b0011 << (2 - idx);
      exp_wdata = (sdata & 32'hFFFF) * 32'h00010001;
      v         = (rdata >> (8 * (2 - idx))) & 32'hFFFF;
      exp_load  = (sgn && v >= 32'h8000) ? v + 32'hFFFF0000 : v;
    end else begin
      exp_be    = 4'hF;
      exp_wdata = sdata;
      exp_load  = rdata;
    end
    exp_rw = !err && !timed_out && rw && !(legal && wr);

    Instr1_IN = instr; Instr1_PC_IN = pc; ALU_result1_IN = addr;
    MemWriteData1_IN = sdata; ALU_Control1_IN = op; MemRead1_IN = rd;
    MemWrite1_IN = wr; RegWrite1_IN = rw; WriteRegister1_IN = wreg;
    dmem_rdata = rdata;
    dmem_ack = (latency == 0);
    #1;
    checkOutput("req_first", dmem_req, legal);
    checkOutput("stall_first", Stall_OUT, legal && latency != 0);
    if (legal) begin
      checkOutput("addr", dmem_addr, addr & 32'hFFFFFFFC);
      checkOutput("be", dmem_be, exp_be);
      checkOutput("we", dmem_we, wr);
      if (wr) checkOutput("wdata", dmem_wdata, exp_wdata);
    end
    stall_cycles = Stall_OUT ? 1 : 0;

    if (legal && latency != 0) begin
      for (int k = 1; k <= TIMEOUT; k++) begin
        @(negedge CLK);
        checkOutput("bubble_rw", RegWrite1_OUT, 0);
        checkOutput("bubble_instr", Instr1_OUT, 0);
        checkOutput("bubble_err", MemErr1_OUT, 0);
        dmem_ack = (k == latency);
        #1;
        checkOutput("req_wait", dmem_req, k < TIMEOUT);
        if (k < TIMEOUT) begin
          checkOutput("addr_wait", dmem_addr, addr & 32'hFFFFFFFC);
          checkOutput("be_wait", dmem_be, exp_be);
        end
        if (Stall_OUT) stall_cycles++;
        if (dmem_ack || k == TIMEOUT) break;
      end
    end
    checkOutput("stall_len", stall_cycles,
                !legal ? 0 : (latency < 0 ? TIMEOUT : latency));

    @(negedge CLK);
    dmem_ack = 1'b0;
    checkOutput("ret_instr", Instr1_OUT, instr);
    checkOutput("ret_pc", Instr1_PC_OUT, pc);
    checkOutput("ret_wreg", WriteRegister1_OUT, wreg);
    checkOutput("ret_err", MemErr1_OUT, err || timed_out);
    checkOutput("ret_rw", RegWrite1_OUT, exp_rw);
    if (!err && !timed_out && !(legal && wr))
      checkOutput("ret_wdata", WriteData1_OUT, (legal && !wr) ? exp_load : addr);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0] ops [8];
    logic [5:0] op;
    int         kind, lat;
    logic       rd, wr;

    ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
    RESET = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    Instr1_IN = '0; Instr1_PC_IN = '0; ALU_result1_IN = '0; MemWriteData1_IN = '0;
    WriteRegister1_IN = '0; RegWrite1_IN = 1'b0; ALU_Control1_IN = '0;
    MemRead1_IN = 1'b0; MemWrite1_IN = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("rst_rw", RegWrite1_OUT, 0);
    checkOutput("rst_err", MemErr1_OUT, 0);
    checkOutput("rst_wd", WriteData1_OUT, 0);
    checkOutput("rst_req", dmem_req, 0);
    RESET = 1'b0;

    applyStimulus(6'h01, 32'h12345678, 0, 0, 0, 0, 1, 5'd3, 1);
    applyStimulus(6'h20, 32'h00001003, 0, 32'hAABBCC80, 1, 0, 1, 5'd4, 0);
    applyStimulus(6'h24, 32'h00001003, 0, 32'hAABBCC80, 1, 0, 1, 5'd5, 0);
    applyStimulus(6'h29, 32'h00002002, 32'h0000BEEF, 0, 0, 1, 0, 5'd0, 3);
    applyStimulus(6'h23, 32'h00003001, 0, 32'h11111111, 1, 0, 1, 5'd6, 0);
    applyStimulus(6'h23, 32'h00004000, 0, 32'h22222222, 1, 0, 1, 5'd7, -1);
    applyStimulus(6'h02, 32'h0BADF00D, 0, 0, 0, 0, 1, 5'd8, 0);
    applyStimulus(6'h21, 32'h00000011, 0, 0, 1, 0, 1, 5'd9, 0);
    applyStimulus(6'h22, 32'h00000100, 0, 0, 1, 0, 1, 5'd10, 0);
    applyStimulus(6'h2B, 32'h00000200, 32'hCAFEBABE, 0, 1, 1, 0, 5'd11, 0);
    applyStimulus(6'h25, 32'h00000502, 0, 32'h1234F00D, 1, 0, 1, 5'd12, 2);

    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      op = ops[$urandom_range(0, 7)];
      rd = (op < 6'h28); wr = !rd;
      if (kind < 2) begin
        op = 6'($urandom_range(0, 15)); rd = 0; wr = 0;
      end else if (kind == 8) begin
        op = 6'h22 + 6'($urandom_range(0, 1) * 8);
      end else if (kind == 9) begin
        rd = 1; wr = 1;
      end
      lat = $urandom_range(0, 4);
      if (lat == 4) lat = -1;
      applyStimulus(op, $urandom, $urandom, $urandom, rd, wr, 1'($urandom),
                    5'($urandom), lat);
    end

    applyStimulus(6'h23, 32'h00006000, 0, 32'h33333333, 1, 0, 1, 5'd13, -1);
    Instr1_IN = 32'h8C0D0000; ALU_result1_IN = 32'h00007000; ALU_Control1_IN = 6'h23;
    MemRead1_IN = 1'b1; MemWrite1_IN = 1'b0; RegWrite1_IN = 1'b1; WriteRegister1_IN = 5'd14;
    dmem_ack = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    MemRead1_IN = 1'b0; RegWrite1_IN = 1'b0; Instr1_IN = '0; Instr1_PC_IN = '0;
    ALU_result1_IN = '0; WriteRegister1_IN = '0;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    checkOutput("rstw_req", dmem_req, 0);
    checkOutput("rstw_stall", Stall_OUT, 0);
    checkOutput("rstw_rw", RegWrite1_OUT, 0);
    checkOutput("rstw_instr", Instr1_OUT, 0);
    checkOutput("rstw_wd", WriteData1_OUT, 0);
    checkOutput("rstw_err", MemErr1_OUT, 0);
    dmem_ack = 1'b1;
    @(negedge CLK);
    dmem_ack = 1'b0;
    checkOutput("late_ack_rw", RegWrite1_OUT, 0);
    checkOutput("late_ack_err", MemErr1_OUT, 0);
    checkOutput("late_ack_wd", WriteData1_OUT, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
